seq_detect_prog: RTL and testbench

//  Run-time programmable serial bit-pattern detector. It replaces fixed-pattern detector FSMs.

---
 rtl/seq_detect_prog_if.sv | 31 +++
 rtl/seq_detect_prog.sv | 110 +++++++++++
 tb/tb_seq_detect_prog.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_prog_if.sv
// Bundles the serial sample, configuration and match/status signals of the pattern detector.
// Use the slave modport on the detector and the master modport on whatever drives it.
interface seq_detect_prog_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             in_valid;
  logic             xin;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic             cfg_err;
  logic             armed;

  modport master (
    output in_valid, xin, cfg_load, cfg_pat, cfg_len, cfg_overlap, cnt_clr,
    input  y, match_cnt, cnt_sat, cfg_err, armed
  );

  modport slave (
    input  in_valid, xin, cfg_load, cfg_pat, cfg_len, cfg_overlap, cnt_clr,
    output y, match_cnt, cnt_sat, cfg_err, armed
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Run-time programmable serial bit-pattern detector with a Mealy match pulse and a saturating match counter.
// y is combinational in the cycle of the last pattern bit; match_cnt/cnt_sat/cfg_err/armed are registered.
module seq_detect_prog #(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 16,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(3'b100),
  parameter int               DEF_LEN = 3,
  parameter logic             DEF_OVL = 1'b0
) (
  input logic              clk,
  input logic              reset,
  seq_detect_prog_if.slave bus
);
  localparam int               LEN_W   = $clog2(PAT_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {FILL, DETECT} state_t;

  state_t           state;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             ovl;
  logic [PAT_W-2:0] hist;
  logic [LEN_W-1:0] fill;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic             cfg_err;

  logic [PAT_W-1:0] win;
  logic [PAT_W-1:0] mask;
  logic             hit;
  logic             y;
  logic             cfg_ok;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] fill_nxt;

  // Window is the stored history with the current bit appended as bit 0.
  always_comb begin
    win  = {hist, bus.xin};
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    hit      = ((win ^ pattern) & mask) == '0;
    y        = !reset && bus.in_valid && !bus.cfg_load && (state == DETECT) && hit;
    cfg_ok   = (bus.cfg_len != '0) && (int'(bus.cfg_len) <= PAT_W);
    last_idx = len - LEN_W'(1);
    fill_nxt = (fill == last_idx) ? fill : fill + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      pattern   <= DEF_PAT;
      len       <= LEN_W'(DEF_LEN);
      ovl       <= DEF_OVL;
      hist      <= '0;
      fill      <= '0;
      cfg_err   <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;

      // A config cycle always swallows the sample, legal or not.
      if (bus.cfg_load) begin
        if (cfg_ok) begin
          pattern <= bus.cfg_pat;
          len     <= bus.cfg_len;
          ovl     <= bus.cfg_overlap;
          hist    <= '0;
          fill    <= '0;
          state   <= (bus.cfg_len == LEN_W'(1)) ? DETECT : FILL;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (bus.in_valid) begin
        hist <= win[PAT_W-2:0];
        if (state == FILL) begin
          fill <= fill_nxt;
          if (fill_nxt == last_idx) begin
            state <= DETECT;
          end
        end else if (y && !ovl) begin
          // A one-bit pattern needs no fill, so it re-arms straight away.
          fill  <= '0;
          state <= (len == LEN_W'(1)) ? DETECT : FILL;
        end else begin
          fill <= fill_nxt;
        end
      end

      if (bus.cnt_clr) begin
        match_cnt <= '0;
        cnt_sat   <= 1'b0;
      end else if (y && (match_cnt != CNT_MAX)) begin
        match_cnt <= match_cnt + CNT_W'(1);
        if (match_cnt + CNT_W'(1) == CNT_MAX) begin
          cnt_sat <= 1'b1;
        end
      end
    end
  end

  assign bus.y         = y;
  assign bus.match_cnt = match_cnt;
  assign bus.cnt_sat   = cnt_sat;
  assign bus.cfg_err   = cfg_err;
  assign bus.armed     = (state == DETECT);
endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios with literal expectations plus a randomized run,
// with two instances (wide and 2-bit counter) checked every cycle against a queue-based reference model.
module tb_seq_detect_prog;
  localparam int PAT_W = 8;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, xin, cfg_load, cfg_overlap, cnt_clr;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  bit [PAT_W-1:0] m_pat = 8'b100;
  int             m_len = 3;
  bit             m_ovl = 1'b0;
  bit             q[$];
  longint         m_count = 0;
  bit             m_err = 1'b0;

  seq_detect_prog_if #(.PAT_W(PAT_W), .CNT_W(16)) bus_a ();
  seq_detect_prog_if #(.PAT_W(PAT_W), .CNT_W(2))  bus_b ();

  assign bus_a.in_valid = in_valid;    assign bus_b.in_valid = in_valid;
  assign bus_a.xin = xin;              assign bus_b.xin = xin;
  assign bus_a.cfg_load = cfg_load;    assign bus_b.cfg_load = cfg_load;
  assign bus_a.cfg_pat = cfg_pat;      assign bus_b.cfg_pat = cfg_pat;
  assign bus_a.cfg_len = cfg_len;      assign bus_b.cfg_len = cfg_len;
  assign bus_a.cfg_overlap = cfg_overlap; assign bus_b.cfg_overlap = cfg_overlap;
  assign bus_a.cnt_clr = cnt_clr;      assign bus_b.cnt_clr = cnt_clr;

  seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(2))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the last len accepted bits since the last clear must equal the pattern (bit 0 = newest).
  function automatic bit model_y();
    if (reset || !in_valid || cfg_load) return 1'b0;
    if (q.size() + 1 < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (((k == 0) ? xin : q[q.size() - k]) != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] sat_cnt(input longint c, input longint mx);
    return 32'((c > mx) ? mx : c);
  endfunction

  always @(posedge clk) begin
    bit yv;
    yv = model_y();
    if (reset) begin
      m_pat = 8'b100; m_len = 3; m_ovl = 1'b0;
      q.delete(); m_count = 0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (cnt_clr) m_count = 0;
      else if (yv) m_count++;
      if (cfg_load) begin
        if (cfg_len >= 1 && cfg_len <= PAT_W) begin
          m_pat = cfg_pat; m_len = int'(cfg_len); m_ovl = cfg_overlap; q.delete();
        end else begin
          m_err = 1'b1;
        end
      end else if (in_valid) begin
        if (yv && !m_ovl) q.delete();
        else begin
          q.push_back(xin);
          if (q.size() > PAT_W) void'(q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("y_a", 32'(bus_a.y), 32'(model_y()));
      chk("y_b", 32'(bus_b.y), 32'(model_y()));
      chk("armed", 32'(bus_a.armed), 32'(q.size() + 1 >= m_len));
      chk("cfg_err", 32'(bus_a.cfg_err), 32'(m_err));
      chk("cnt_a", 32'(bus_a.match_cnt), sat_cnt(m_count, 65535));
      chk("sat_a", 32'(bus_a.cnt_sat), 32'(m_count >= 65535));
      chk("cnt_b", 32'(bus_b.match_cnt), sat_cnt(m_count, 3));
      chk("sat_b", 32'(bus_b.cnt_sat), 32'(m_count >= 3));
    end
  end

  task automatic send(input bit v, input bit b, input bit ey, input string nm);
    in_valid = v; xin = b;
    @(negedge clk);
    chk(nm, 32'(bus_a.y), 32'(ey));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic stream(input bit [15:0] bits, input bit [15:0] ey, input int n, input string nm);
    for (int i = n - 1; i >= 0; i--) send(1'b1, bits[i], ey[i], nm);
  endtask

  task automatic load(input bit [PAT_W-1:0] p, input int l, input bit o);
    cfg_load = 1'b1; cfg_pat = p; cfg_len = LEN_W'(l); cfg_overlap = o;
    in_valid = 1'b1; xin = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    cfg_load = 1'b0; in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; xin = 1'b0; cfg_load = 1'b0;
    cfg_pat = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_cnt", 32'(bus_a.match_cnt), 0);
    chk("rst_sat", 32'(bus_a.cnt_sat), 0);
    chk("rst_err", 32'(bus_a.cfg_err), 0);
    chk("rst_armed", 32'(bus_a.armed), 0);

    stream(16'b1100100, 16'b0001001, 7, "t1_y");
    chk("t1_cnt", 32'(bus_a.match_cnt), 2);

    load(8'b101, 3, 1'b1);
    stream(16'b10101, 16'b00101, 5, "t2_ovl_y");
    load(8'b101, 3, 1'b0);
    stream(16'b10101, 16'b00100, 5, "t2_novl_y");

    load(8'b1, 1, 1'b1);
    chk("t3_armed", 32'(bus_a.armed), 1);
    send(1, 1, 1, "t3_y"); send(0, 1, 0, "t3_gap");
    send(1, 1, 1, "t3_y"); send(0, 1, 0, "t3_gap");
    send(1, 0, 0, "t3_y"); send(0, 1, 0, "t3_gap");
    send(1, 1, 1, "t3_y");

    load(8'b101, 3, 1'b1);
    cfg_load = 1'b1; cfg_len = '0; cfg_pat = 8'hff;
    @(posedge clk); #1;
    chk("t4_err_len0", 32'(bus_a.cfg_err), 1);
    cfg_len = LEN_W'(PAT_W + 1);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    chk("t4_err_len9", 32'(bus_a.cfg_err), 1);
    stream(16'b101, 16'b001, 3, "t4_y");
    chk("t4_err_clr", 32'(bus_a.cfg_err), 0);

    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    load(8'b1, 1, 1'b1);
    repeat (5) send(1, 1, 1, "t5_y");
    chk("t5_cnt_b", 32'(bus_b.match_cnt), 3);
    chk("t5_sat_b", 32'(bus_b.cnt_sat), 1);
    chk("t5_cnt_a", 32'(bus_a.match_cnt), 5);
    cnt_clr = 1'b1;
    send(1, 1, 1, "t5_clr_y");
    cnt_clr = 1'b0;
    chk("t5_clr_cnt_a", 32'(bus_a.match_cnt), 0);
    chk("t5_clr_cnt_b", 32'(bus_b.match_cnt), 0);
    chk("t5_clr_sat_b", 32'(bus_b.cnt_sat), 0);

    pulse_reset();
    stream(16'b10, 16'b00, 2, "t6_pre");
    pulse_reset();
    send(1, 0, 0, "t6_after_rst");
    chk("t6_armed", 32'(bus_a.armed), 0);
    stream(16'b100, 16'b001, 3, "t6_default");

    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      reset       = (r == 0);
      cfg_load    = (r >= 1 && r <= 4);
      cnt_clr     = ($urandom_range(0, 49) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      xin         = 1'($urandom_range(0, 1));
      cfg_pat     = PAT_W'($urandom);
      cfg_len     = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(9, 15))
                                                : LEN_W'($urandom_range(0, 5));
      cfg_overlap = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    reset = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
